// File: rtl/tt_capture.sv
// Truth-table capture stage: accepts 16 in-order result triples, checks them
// against the golden equations, stores them and reports pass/fail.
module tt_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_row,
  input  logic [2:0] in_r,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_cnt,
  output logic [4:0] r1_cnt,
  output logic [4:0] r3_cnt,
  output logic       seq_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [4:0] CNT_MAX = 5'd16;

  state_t      state;
  logic [3:0]  exp_row;
  logic [15:0] valid;
  logic [2:0]  tbl [16];

  logic       w, x, y, z;
  logic       g1, g2, g3;
  logic [2:0] golden;
  logic       arm, accept, write;

  always_comb begin
    {w, x, y, z} = in_row;
    g1     = x | (~y & z);
    g2     = ~(~(~y & z) & ~x);
    g3     = (w & x & y & z) | (~w & ~x & ~y & ~z);
    golden = {g3, g2, g1};
    arm    = start && (state != CAPTURE);
    accept = in_valid && in_ready;
    write  = accept && (in_row == exp_row);
  end

  function automatic logic [4:0] sat_inc(input logic [4:0] c, input logic en);
    return (en && c != CNT_MAX) ? c + 5'd1 : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail_cnt <= '0;
      r1_cnt   <= '0;
      r3_cnt   <= '0;
      seq_err  <= 1'b0;
      exp_row  <= '0;
      valid    <= '0;
    end else if (arm) begin
      state    <= CAPTURE;
      in_ready <= 1'b1;
      busy     <= 1'b1;
      done     <= 1'b0;
      fail_cnt <= '0;
      r1_cnt   <= '0;
      r3_cnt   <= '0;
      seq_err  <= 1'b0;
      exp_row  <= '0;
      valid    <= '0;
    end else if (state == CAPTURE && accept) begin
      if (write) begin
        valid[in_row] <= 1'b1;
        fail_cnt      <= sat_inc(fail_cnt, in_r != golden);
        r1_cnt        <= sat_inc(r1_cnt, in_r[0]);
        r3_cnt        <= sat_inc(r3_cnt, in_r[2]);
        exp_row       <= exp_row + 4'd1;
        if (in_row == 4'd15) begin
          state    <= DONE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
      end else begin
        seq_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write)
      tbl[in_row] <= in_r;
  end

  // Read reflects the table as it stands after this edge: a start clears it,
  // a same-address write is forwarded.
  always_ff @(posedge clk) begin
    if (rst || arm)
      rd_data <= '0;
    else if (write && in_row == rd_addr)
      rd_data <= in_r;
    else
      rd_data <= valid[rd_addr] ? tbl[rd_addr] : 3'b000;
  end

  assign pass = done && (fail_cnt == 5'd0) && !seq_err;

endmodule

// File: tb/tb_tt_capture.sv
// Directed bench for tt_capture with a behavioural table/counter model checked
// every cycle, plus literal end-of-run expectations.
module tb_tt_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_row = '0;
  logic [2:0] in_r = '0;
  logic [3:0] rd_addr = '0;
  logic [2:0] rd_data;
  logic       busy, done, pass, seq_err;
  logic [4:0] fail_cnt, r1_cnt, r3_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  tt_capture dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_row(in_row), .in_r(in_r), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .r1_cnt(r1_cnt), .r3_cnt(r3_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] gold(input int r);
    bit x, y, z, g1;
    x  = r[2];
    y  = r[1];
    z  = r[0];
    g1 = x || (!y && z);
    return {(r == 0 || r == 15), g1, g1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 capturing, 2 finished.
  int         m_mode = 0;
  int         m_exp = 0;
  int         m_fail = 0, m_r1 = 0, m_r3 = 0;
  bit         m_seq = 0;
  bit         m_valid [16];
  logic [2:0] m_tbl [16];
  logic [2:0] m_rd = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_exp = 0; m_fail = 0; m_r1 = 0; m_r3 = 0; m_seq = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
      m_rd = '0;
    end else begin
      if (start && m_mode != 1) begin
        m_mode = 1; m_exp = 0; m_fail = 0; m_r1 = 0; m_r3 = 0; m_seq = 0;
        foreach (m_valid[i]) m_valid[i] = 0;
      end else if (m_mode == 1 && in_valid) begin
        if (int'(in_row) == m_exp) begin
          m_tbl[in_row]   = in_r;
          m_valid[in_row] = 1;
          if (in_r != gold(int'(in_row))) m_fail = (m_fail < 16) ? m_fail + 1 : 16;
          if (in_r[0]) m_r1 = (m_r1 < 16) ? m_r1 + 1 : 16;
          if (in_r[2]) m_r3 = (m_r3 < 16) ? m_r3 + 1 : 16;
          if (m_exp == 15) m_mode = 2;
          m_exp = (m_exp + 1) % 16;
        end else begin
          m_seq = 1;
        end
      end
      m_rd = m_valid[rd_addr] ? m_tbl[rd_addr] : 3'b000;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, m_mode == 1);
      check("busy", busy, m_mode == 1);
      check("done", done, m_mode == 2);
      check("pass", pass, m_mode == 2 && m_fail == 0 && !m_seq);
      check("fail_cnt", fail_cnt, m_fail);
      check("r1_cnt", r1_cnt, m_r1);
      check("r3_cnt", r3_cnt, m_r3);
      check("seq_err", seq_err, m_seq);
      check("rd_data", rd_data, m_rd);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int row, input logic [2:0] r, input int gap);
    in_valid = 1'b1;
    in_row   = 4'(row);
    in_r     = r;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic read_at(input int a);
    rd_addr = 4'(a);
    tick();
  endtask

  task automatic golden_rows(input int from, input int upto, input bit gaps);
    for (int r = from; r <= upto; r++) send(r, gold(r), gaps ? (r % 3) + 1 : 0);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_rd", rd_data, 0);

    // in_valid while idle is ignored
    send(3, 3'b111, 1);
    check("idle_r1", r1_cnt, 0);

    // golden run, with a same-cycle read of the row being written
    do_start();
    for (int r = 0; r <= 15; r++) begin
      rd_addr = 4'(r);
      send(r, gold(r), 0);
    end
    check("gold_done", done, 1);
    check("gold_pass", pass, 1);
    check("gold_fail", fail_cnt, 0);
    check("gold_r1", r1_cnt, 10);
    check("gold_r3", r3_cnt, 2);
    read_at(15);
    check("gold_rd15", rd_data, 3'b111);
    read_at(5);
    check("gold_rd5", rd_data, 3'b011);

    // fault injection at row 5
    do_start();
    golden_rows(0, 4, 0);
    send(5, 3'b001, 0);
    golden_rows(6, 15, 0);
    check("fault_fail", fail_cnt, 1);
    check("fault_pass", pass, 0);
    read_at(5);
    check("fault_rd5", rd_data, 3'b001);

    // out-of-order row
    do_start();
    golden_rows(0, 1, 0);
    send(3, gold(3), 0);
    check("ooo_seq", seq_err, 1);
    read_at(3);
    check("ooo_rd3", rd_data, 0);
    golden_rows(2, 15, 0);
    check("ooo_done", done, 1);
    check("ooo_pass", pass, 0);

    // restart from DONE with a simultaneous beat
    start = 1'b1; in_valid = 1'b1; in_row = 4'd0; in_r = gold(0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("rst_busy", busy, 1);
    check("rst_r3", r3_cnt, 0);
    check("rst_seq", seq_err, 0);
    golden_rows(0, 15, 0);
    check("restart_pass", pass, 1);

    // mid-capture reset, then a stalled golden run
    do_start();
    golden_rows(0, 7, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_r1", r1_cnt, 0);
    read_at(3);
    check("mid_rd3", rd_data, 0);
    send(0, gold(0), 0);
    check("mid_idle_r3", r3_cnt, 0);
    do_start();
    golden_rows(0, 15, 1);
    check("stall_pass", pass, 1);
    check("stall_r1", r1_cnt, 10);
    check("stall_r3", r3_cnt, 2);
    read_at(0);
    check("stall_rd0", rd_data, 3'b100);

    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
